// File: rtl/unidade_controle.sv
// Multicycle MIPS-style main control: Moore FSM sequencing fetch/decode/execute
// and driving datapath mux selects and strobes purely from the current state.
module unidade_controle (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_LW_WB     = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_ILLEGAL   = 4'd13
  } state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;
  } ctrl_t;

  state_t     state_q, state_d;
  logic [5:0] opcode_q;
  ctrl_t      ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_RESET;
      opcode_q <= '0;
    end else begin
      state_q <= state_d;
      // MEM_ADDR must branch on the decoded instruction, not whatever the IR
      // bus shows later.
      if (state_q == S_DECODE) opcode_q <= opcode;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = S_R_EXEC;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_ADDI:       state_d = S_ADDI_EXEC;
          default:       state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = S_LW_WB;
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: ctrl.alu_src_b = 2'b11;
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_LW_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = 2'b10;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = 2'b01;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
      end
      S_ADDI_WB:  ctrl.reg_write  = 1'b1;
      S_ILLEGAL:  ctrl.illegal_op = 1'b1;
      default:    ctrl = '0;
    endcase
  end

  assign alu_op        = ctrl.alu_op;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_source     = ctrl.pc_source;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign illegal_op    = ctrl.illegal_op;
  assign state         = state_q;

endmodule
